// File: rtl/cnt_seq_chk.sv
// Sequence checker for a WIDTH-bit step counter: lock/track/fault FSM, wrap detection and tally.
// Optional err_cnt output enabled by defining CNT_SEQ_CHK_ERRCNT_EN.
module cnt_seq_chk #(
    parameter int WIDTH     = 3,
    parameter int DIR       = 0,
    parameter int LOCK_N    = 2,
    parameter int ERR_LIMIT = 2,
    parameter int WRAP_W    = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              en,
    input  logic [WIDTH-1:0]  cnt_in,
    input  logic              clr_err,
    output logic              locked,
    output logic              err,
    output logic              fault,
    output logic              tc_pulse,
    output logic [WRAP_W-1:0] wrap_cnt
`ifdef CNT_SEQ_CHK_ERRCNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, ACQ, TRACK, FAULT} state_t;

    state_t            state_reg;
    logic [WIDTH-1:0]  prv_cnt_reg;
    logic              prv_en_reg;
    logic              prv_valid_reg;
    logic [3:0]        match_ctr_reg;
    logic [3:0]        miss_ctr_reg;
    logic              locked_reg;
    logic              err_reg;
    logic              fault_reg;
    logic              tc_pulse_reg;
    logic [WRAP_W-1:0] wrap_cnt_reg;
`ifdef CNT_SEQ_CHK_ERRCNT_EN
    logic [7:0]        err_cnt_reg;
`endif

    logic [WIDTH-1:0]  exp_val;
    logic              match;
    logic              wrap;

    // Expected value and wrap condition depend only on count direction.
    generate
        if (DIR == 0) begin : g_up
            assign exp_val = prv_cnt_reg + WIDTH'(prv_en_reg);
            assign wrap    = prv_en_reg && (prv_cnt_reg == '1) && (cnt_in == '0);
        end else begin : g_down
            assign exp_val = prv_cnt_reg - WIDTH'(prv_en_reg);
            assign wrap    = prv_en_reg && (prv_cnt_reg == '0) && (cnt_in == '1);
        end
    endgenerate

    assign match = prv_valid_reg && (cnt_in == exp_val);

    always_ff @(posedge clk) begin
        if (res) begin
            state_reg     <= IDLE;
            prv_cnt_reg   <= '0;
            prv_en_reg    <= 1'b0;
            prv_valid_reg <= 1'b0;
            match_ctr_reg <= '0;
            miss_ctr_reg  <= '0;
            locked_reg    <= 1'b0;
            err_reg       <= 1'b0;
            fault_reg     <= 1'b0;
            tc_pulse_reg  <= 1'b0;
            wrap_cnt_reg  <= '0;
`ifdef CNT_SEQ_CHK_ERRCNT_EN
            err_cnt_reg   <= '0;
`endif
        end else begin
            prv_cnt_reg   <= cnt_in;
            prv_en_reg    <= en;
            prv_valid_reg <= 1'b1;
            err_reg       <= 1'b0;
            tc_pulse_reg  <= 1'b0;
            if (clr_err) begin
                // wrap_cnt deliberately survives a clear
                state_reg     <= IDLE;
                match_ctr_reg <= '0;
                miss_ctr_reg  <= '0;
                locked_reg    <= 1'b0;
                fault_reg     <= 1'b0;
`ifdef CNT_SEQ_CHK_ERRCNT_EN
                err_cnt_reg   <= '0;
`endif
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg     <= ACQ;
                        match_ctr_reg <= '0;
                        miss_ctr_reg  <= '0;
                    end
                    ACQ: begin
                        if (match) begin
                            if (wrap) begin
                                tc_pulse_reg <= 1'b1;
                                if (wrap_cnt_reg != '1)
                                    wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
                            end
                            if (match_ctr_reg + 4'd1 >= 4'(LOCK_N)) begin
                                state_reg     <= TRACK;
                                locked_reg    <= 1'b1;
                                match_ctr_reg <= '0;
                                miss_ctr_reg  <= '0;
                            end else begin
                                match_ctr_reg <= match_ctr_reg + 4'd1;
                            end
                        end else begin
                            match_ctr_reg <= '0;
                        end
                    end
                    TRACK: begin
                        if (match) begin
                            miss_ctr_reg <= '0;
                            if (wrap) begin
                                tc_pulse_reg <= 1'b1;
                                if (wrap_cnt_reg != '1)
                                    wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
                            end
                        end else begin
                            err_reg <= 1'b1;
`ifdef CNT_SEQ_CHK_ERRCNT_EN
                            if (err_cnt_reg != 8'hFF)
                                err_cnt_reg <= err_cnt_reg + 8'd1;
`endif
                            if (miss_ctr_reg + 4'd1 >= 4'(ERR_LIMIT)) begin
                                state_reg    <= FAULT;
                                locked_reg   <= 1'b0;
                                fault_reg    <= 1'b1;
                                miss_ctr_reg <= '0;
                            end else begin
                                miss_ctr_reg <= miss_ctr_reg + 4'd1;
                            end
                        end
                    end
                    FAULT: begin
                        locked_reg <= 1'b0;
                        fault_reg  <= 1'b1;
                    end
                    default: begin
                        state_reg  <= IDLE;
                        locked_reg <= 1'b0;
                        fault_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign locked   = locked_reg;
    assign err      = err_reg;
    assign fault    = fault_reg;
    assign tc_pulse = tc_pulse_reg;
    assign wrap_cnt = wrap_cnt_reg;
`ifdef CNT_SEQ_CHK_ERRCNT_EN
    assign err_cnt  = err_cnt_reg;
`endif

endmodule

// File: tb/tb_cnt_seq_chk.sv
// Testbench for cnt_seq_chk: directed scenarios plus randomized stimulus against a behavioural model.
// A second instance with WRAP_W=2 shares the stimulus to exercise wrap-count saturation.
module tb_cnt_seq_chk;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       en = 1'b0;
    logic       clr_err = 1'b0;
    logic [2:0] cnt_in = 3'd0;
    logic       locked, err, fault, tc_pulse;
    logic [7:0] wrap_cnt;
    logic       locked2, err2, fault2, tc_pulse2;
    logic [1:0] wrap_cnt2;
`ifdef CNT_SEQ_CHK_ERRCNT_EN
    logic [7:0] err_cnt, err_cnt2;
`endif

    always #5 clk = ~clk;

    cnt_seq_chk #(.WIDTH(3), .DIR(0), .LOCK_N(2), .ERR_LIMIT(2), .WRAP_W(8)) dut (
        .clk(clk), .res(res), .en(en), .cnt_in(cnt_in), .clr_err(clr_err),
        .locked(locked), .err(err), .fault(fault), .tc_pulse(tc_pulse), .wrap_cnt(wrap_cnt)
`ifdef CNT_SEQ_CHK_ERRCNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    cnt_seq_chk #(.WIDTH(3), .DIR(0), .LOCK_N(2), .ERR_LIMIT(2), .WRAP_W(2)) dut_sat (
        .clk(clk), .res(res), .en(en), .cnt_in(cnt_in), .clr_err(clr_err),
        .locked(locked2), .err(err2), .fault(fault2), .tc_pulse(tc_pulse2), .wrap_cnt(wrap_cnt2)
`ifdef CNT_SEQ_CHK_ERRCNT_EN
        , .err_cnt(err_cnt2)
`endif
    );

    // Behavioural model: mode 0=idle 1=acquire 2=tracking 3=fault
    int  mode = 0;
    int  good = 0, bad = 0;
    int  p_cnt = 0;
    bit  p_en = 0, have_prev = 0;
    bit  m_err = 0, m_tc = 0;
    int  m_wc = 0, m_wc2 = 0, m_ec = 0;
    int  cnt = 0;
    int  checks = 0, errors = 0;

    logic [13:0] obs_vec;
    assign obs_vec = {locked, err, fault, tc_pulse, wrap_cnt, wrap_cnt2};

    function automatic logic [13:0] exp_vec();
        logic [7:0] w8;
        logic [1:0] w2;
        w8 = m_wc[7:0];
        w2 = m_wc2[1:0];
        return {mode == 2, m_err, mode == 3, m_tc, w8, w2};
    endfunction

    task automatic model_edge(bit r, bit c, bit e, int v);
        bit ok, wrapped;
        m_err = 0;
        m_tc  = 0;
        if (r) begin
            mode = 0; good = 0; bad = 0; m_wc = 0; m_wc2 = 0; m_ec = 0;
            have_prev = 0; p_cnt = 0; p_en = 0;
        end else begin
            ok      = have_prev && (v == (p_cnt + int'(p_en)) % 8);
            wrapped = p_en && p_cnt == 7 && v == 0;
            if (c) begin
                mode = 0; good = 0; bad = 0; m_ec = 0;
            end else if (mode == 0) begin
                mode = 1;
            end else if (mode == 1 || mode == 2) begin
                if (ok && wrapped) begin
                    m_tc  = 1;
                    m_wc  = (m_wc < 255) ? m_wc + 1 : 255;
                    m_wc2 = (m_wc2 < 3) ? m_wc2 + 1 : 3;
                end
                if (mode == 1) begin
                    good = ok ? good + 1 : 0;
                    if (good >= 2) begin
                        mode = 2; bad = 0;
                    end
                end else if (ok) begin
                    bad = 0;
                end else begin
                    m_err = 1;
                    m_ec  = (m_ec < 255) ? m_ec + 1 : 255;
                    bad++;
                    if (bad >= 2) mode = 3;
                end
            end
            p_cnt = v; p_en = e; have_prev = 1;
        end
    endtask

    task automatic drive(bit r, bit c, bit e, int v);
        logic [31:0] vv;
        vv      = 32'(v);
        res     = r;
        clr_err = c;
        en      = e;
        cnt_in  = vv[2:0];
        @(posedge clk);
        model_edge(r, c, e, v);
        #1;
    endtask

    task automatic step(bit e);
        drive(0, 0, e, cnt);
        cnt = (cnt + int'(e)) % 8;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
            checks++;
            if (obs_vec !== 14'd0) begin
                errors++;
                $display("FAIL reset_hold edge %0d: got %h want 0000", i, obs_vec);
            end
        end
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (locked !== (i == 2) || obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_lock sample %0d: got locked=%b vec=%h want locked=%b vec=%h",
                         i, locked, obs_vec, (i == 2), exp_vec());
            end
        end
        $display("test_reset done: locked=%b", locked);
    endtask

    task automatic test_wrap();
        int v, pulses;
        pulses = 0;
        for (int i = 0; i < 7; i++) begin
            v = cnt;
            step(1);
            checks++;
            if (tc_pulse !== (v == 0) || obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL wrap_pulse sample %0d: got tc=%b vec=%h want tc=%b vec=%h",
                         v, tc_pulse, obs_vec, (v == 0), exp_vec());
            end
        end
        checks++;
        if (wrap_cnt !== 8'd1) begin
            errors++;
            $display("FAIL wrap_first: got wrap_cnt=%0d want 1", wrap_cnt);
        end
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (tc_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2 || wrap_cnt !== 8'd3 || wrap_cnt2 !== 2'd3) begin
            errors++;
            $display("FAIL wrap_tally: got pulses=%0d wrap_cnt=%0d wrap_cnt2=%0d want 2 3 3",
                     pulses, wrap_cnt, wrap_cnt2);
        end
        $display("test_wrap done: wrap_cnt=%0d", wrap_cnt);
    endtask

    task automatic test_hold();
        for (int i = 0; i < 8 && cnt != 5; i++) step(1);
        for (int i = 0; i < 6; i++) begin
            step(i >= 4);
            checks++;
            if (err !== 1'b0 || locked !== 1'b1 || tc_pulse !== 1'b0 || obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL hold edge %0d: got err=%b locked=%b tc=%b vec=%h want 0 1 0 vec=%h",
                         i, err, locked, tc_pulse, obs_vec, exp_vec());
            end
        end
        $display("test_hold done: cnt_in=%0d locked=%b", cnt_in, locked);
    endtask

    task automatic test_glitch();
        int seq [4] = '{3, 6, 7, 0};
        for (int i = 0; i < 8 && cnt != 3; i++) step(1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, seq[i]);
            checks++;
            if (err !== (i == 1) || fault !== 1'b0 || locked !== 1'b1 ||
                tc_pulse !== (i == 3) || obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL glitch sample %0d: got err=%b fault=%b locked=%b tc=%b want %b 0 1 %b",
                         seq[i], err, fault, locked, tc_pulse, (i == 1), (i == 3));
            end
        end
        cnt = 1;
        $display("test_glitch done: err=%b locked=%b", err, locked);
    endtask

    task automatic test_fault_clear();
        logic [7:0] saved;
        int seq [3] = '{2, 5, 1};
        for (int i = 0; i < 8 && cnt != 2; i++) step(1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, seq[i]);
            checks++;
            if (err !== (i > 0) || fault !== (i == 2) || locked !== (i < 2) || obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL fault_seq sample %0d: got err=%b fault=%b locked=%b want %b %b %b",
                         seq[i], err, fault, locked, (i > 0), (i == 2), (i < 2));
            end
        end
        saved = wrap_cnt;
        drive(0, 1, 1, 2);
        checks++;
        if (fault !== 1'b0 || locked !== 1'b0 || err !== 1'b0 || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL fault_clear: got fault=%b locked=%b err=%b want 0 0 0", fault, locked, err);
        end
        cnt = 3;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (locked !== (i == 2) || wrap_cnt !== saved || obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL fault_relock sample %0d: got locked=%b wrap_cnt=%0d want %b %0d",
                         i, locked, wrap_cnt, (i == 2), saved);
            end
        end
        $display("test_fault_clear done: locked=%b wrap_cnt=%0d", locked, wrap_cnt);
    endtask

    task automatic test_clr_priority();
        int bv;
        bv = (cnt + 3) % 8;
        drive(0, 1, 1, bv);
        checks++;
        if (err !== 1'b0 || locked !== 1'b0 || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL clr_priority: got err=%b locked=%b want 0 0", err, locked);
        end
        cnt = (bv + 1) % 8;
        repeat (3) step(1);
        $display("test_clr_priority done: locked=%b", locked);
    endtask

    task automatic test_random();
        int r, v;
        bit e, c, rs;
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 99));
            e  = ($urandom_range(0, 3) != 0);
            c  = (r == 99);
            rs = (r == 98);
            v  = (r < 8) ? int'($urandom_range(0, 7)) : cnt;
            drive(rs, c, e, v);
            cnt = (v + int'(e)) % 8;
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random cycle %0d: got vec=%h want vec=%h", i, obs_vec, exp_vec());
            end
`ifdef CNT_SEQ_CHK_ERRCNT_EN
            checks++;
            if (err_cnt !== 8'(m_ec)) begin
                errors++;
                $display("FAIL random_errcnt cycle %0d: got %0d want %0d", i, err_cnt, m_ec);
            end
`endif
        end
        $display("test_random done: wrap_cnt=%0d mode=%0d", wrap_cnt, mode);
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 42; i++) begin
            step(1);
            checks++;
            if (obs_vec !== exp_vec()) begin
                errors++;
                $display("FAIL sat_run step %0d: got vec=%h want vec=%h", i, obs_vec, exp_vec());
            end
        end
        checks++;
        if (wrap_cnt2 !== 2'd3 || wrap_cnt !== 8'd5) begin
            errors++;
            $display("FAIL sat_value: got wrap_cnt2=%0d wrap_cnt=%0d want 3 5", wrap_cnt2, wrap_cnt);
        end
        $display("test_saturation done: wrap_cnt=%0d wrap_cnt2=%0d", wrap_cnt, wrap_cnt2);
    endtask

    task automatic test_midrun_reset();
        drive(0, 0, 1, (cnt + 5) % 8);
        drive(1, 0, 1, cnt);
        checks++;
        if (obs_vec !== 14'd0 || obs_vec !== exp_vec()) begin
            errors++;
            $display("FAIL midrun_reset: got vec=%h want 0000", obs_vec);
        end
`ifdef CNT_SEQ_CHK_ERRCNT_EN
        checks++;
        if (err_cnt !== 8'd0 || err_cnt2 !== 8'd0) begin
            errors++;
            $display("FAIL midrun_reset_errcnt: got %0d %0d want 0 0", err_cnt, err_cnt2);
        end
`endif
        $display("test_midrun_reset done: vec=%h", obs_vec);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wrap();
        test_hold();
        test_glitch();
        test_fault_clear();
        test_clr_priority();
        test_random();
        test_saturation();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
